ram_wr_queue: RTL and testbench
===============================

// Module: ram_wr_queue
// PURPOSE
//  Write-side front end for the multi-port sync RAMs (2-write variants). Buffers up to two
//  write requests per cycle in a FIFO and drains up to two per cycle onto waddr1/2, wdata1/2,
//  we1/we2 in program order. Optionally clears the RAM after reset before accepting traffic.
// PARAMETERS
//  ADDR_WIDTH   5   RAM address width
//  DATA_WIDTH   32  RAM data width
//  DATA_DEPTH   32  RAM entries to clear on init (1..2**ADDR_WIDTH)
//  QUEUE_DEPTH  8   FIFO entries; power of 2, >=2
// PORTS
//  clk        in   1                  clock, all state on posedge
//  reset      in   1                  asynchronous, active-high
//  in_valid1  in   1                  request 1 valid (older of the pair)
//  in_addr1   in   ADDR_WIDTH         request 1 address
//  in_data1   in   DATA_WIDTH         request 1 data
//  in_valid2  in   1                  request 2 valid (younger)
//  in_addr2   in   ADDR_WIDTH         request 2 address
//  in_data2   in   DATA_WIDTH         request 2 data
//  in_ready   out  1                  queue accepts this cycle
//  drain_en   in   1                  1 = pop to RAM allowed this cycle
//  we1/we2    out  1                  RAM write enables (registered)
//  waddr1/2   out  ADDR_WIDTH         RAM write addresses (registered)
//  wdata1/2   out  DATA_WIDTH         RAM write data (registered)
//  count      out  clog2(QD)+1        occupied entries
//  init_done  out  1                  1 once in RUN
// BEHAVIOUR
//  - Reset (async): head/tail/count=0; we1=we2=0, waddr=0, wdata=0; state INIT if macro else RUN.
//  - in_ready = (state==RUN) && (QUEUE_DEPTH-count >= 2); combinational, pure of in_valid*.
//  - Enqueue when in_ready: valid1 -> slot tail; valid2 -> tail+valid1. valid2 alone legal.
//    Requests with in_ready=0 are ignored (requester holds).
//  - Drain (RUN, drain_en=1): registered on the edge: we1<=1 from head if count>=1;
//    we2<=1 from head+1 if count>=2; else we=0. drain_en=0 or empty -> we1=we2=0.
//  - Order: port1 always older than port2 -> same-address pair: port2 data ends in RAM.
//  - Latency: accepted at edge E0, driven on we*/waddr* after E1, RAM written at E2.
//  - Enqueue and drain same cycle: count <= count + n_in - n_out; n_out uses pre-edge count
//    (no same-cycle bypass of just-enqueued entries).
//  - Pointers wrap modulo QUEUE_DEPTH; count never exceeds QUEUE_DEPTH.
//  - FSM: INIT -> RUN after last clear pair; RUN terminal until reset.
//  - Reset mid-operation: queued and in-flight writes discarded, outputs cleared immediately.
// CONFIGURATION
//  RAM_WR_QUEUE_INIT_EN defined: after reset state INIT; each cycle drive we1=1 addr=idx,
//   we2=1 addr=idx+1 (we2=0 if idx+1>=DATA_DEPTH), wdata=0, idx+=2; ignores drain_en;
//   ceil(DATA_DEPTH/2) cycles then RUN; in_ready=0, init_done=0 during INIT.
//  Not defined: reset goes straight to RUN; init_done=1 and in_ready=1 out of reset.
// TESTING
//  1 INIT_EN, DEPTH 32: release reset -> 16 cycles of we pairs (0,1)..(30,31) data 0, then init_done=1.
//  2 Single write addr 5 data 32'hDEADBEEF, drain_en=1 -> next cycle we1=1 waddr1=5, we2=0, count=0.
//  3 Pair addr 3/3 data 32'hA/32'hB -> same cycle we1(3,A), we2(3,B); RAM read of 3 returns B.
//  4 drain_en=0, 2 writes/cycle x4 (QD 8) -> count 6 ready=1, then count 8 ready=0; drain_en=1 -> 4 pairs in order.
//  5 count=3, drain_en=1 -> cycle1 we1+we2 (entries 0,1), cycle2 we1 only (entry 2), then we=0.
//  6 reset pulse with count=5 mid-drain -> we1=we2=0 and count=0 immediately; init reruns if INIT_EN.

Source files
------------

// File: rtl/ram_wr_queue.sv
// ram_wr_queue: write-side front end for a two-write-port sync RAM.
// Accepts up to two write requests per cycle into a circular queue and
// drains up to two per cycle onto registered we/waddr/wdata pairs, oldest
// entry always on port 1.
// Optional post-reset RAM clear: define RAM_WR_QUEUE_INIT_EN.
//
//   state | meaning
//   INIT  | clearing RAM two entries per cycle, queue closed
//   RUN   | normal queueing and draining, terminal until reset
module ram_wr_queue #(
    parameter int ADDR_WIDTH  = 5,
    parameter int DATA_WIDTH  = 32,
    parameter int DATA_DEPTH  = 32,
    parameter int QUEUE_DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid1,
    input  logic [ADDR_WIDTH-1:0]          in_addr1,
    input  logic [DATA_WIDTH-1:0]          in_data1,
    input  logic                           in_valid2,
    input  logic [ADDR_WIDTH-1:0]          in_addr2,
    input  logic [DATA_WIDTH-1:0]          in_data2,
    output logic                           in_ready,
    input  logic                           drain_en,
    output logic                           we1,
    output logic                           we2,
    output logic [ADDR_WIDTH-1:0]          waddr1,
    output logic [ADDR_WIDTH-1:0]          waddr2,
    output logic [DATA_WIDTH-1:0]          wdata1,
    output logic [DATA_WIDTH-1:0]          wdata2,
    output logic [$clog2(QUEUE_DEPTH):0]   count,
    output logic                           init_done
);
    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] READY_MAX = CW'(QUEUE_DEPTH - 2);

    if (QUEUE_DEPTH < 2 || (QUEUE_DEPTH & (QUEUE_DEPTH - 1)) != 0) begin : g_bad_qd
        $error("ram_wr_queue: QUEUE_DEPTH must be a power of 2 and >= 2");
    end
    if (DATA_DEPTH < 1 || DATA_DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_dd
        $error("ram_wr_queue: DATA_DEPTH must be in 1..2**ADDR_WIDTH");
    end

    typedef enum logic {ST_INIT, ST_RUN} state_t;
    state_t state;

    logic [ADDR_WIDTH-1:0] q_addr [QUEUE_DEPTH];
    logic [DATA_WIDTH-1:0] q_data [QUEUE_DEPTH];
    logic [PW-1:0]         head, tail, head_p1, slot2;
    logic [1:0]            n_in, n_out;
    logic                  run;

    assign run      = (state == ST_RUN);
    assign in_ready = run && (count <= READY_MAX);
    assign head_p1  = head + PW'(1);
    assign slot2    = tail + PW'(in_valid1);
    assign n_in     = in_ready ? ({1'b0, in_valid1} + {1'b0, in_valid2}) : 2'd0;
    // Pops only see entries present before the edge; no bypass of new arrivals.
    assign n_out    = (run && drain_en) ? ((count >= CW'(2)) ? 2'd2 : count[1:0]) : 2'd0;

`ifdef RAM_WR_QUEUE_INIT_EN
    localparam logic [ADDR_WIDTH:0] DD = (ADDR_WIDTH + 1)'(DATA_DEPTH);
    logic [ADDR_WIDTH:0] init_idx, init_idx_p1, init_idx_p2;
    assign init_idx_p1 = init_idx + (ADDR_WIDTH + 1)'(1);
    assign init_idx_p2 = init_idx + (ADDR_WIDTH + 1)'(2);
`endif

    // Queue storage: older request lands at tail, younger right behind it.
    always_ff @(posedge clk) begin
        if (in_ready && in_valid1) begin
            q_addr[tail] <= in_addr1;
            q_data[tail] <= in_data1;
        end
        if (in_ready && in_valid2) begin
            q_addr[slot2] <= in_addr2;
            q_data[slot2] <= in_data2;
        end
    end

    // Pointers and occupancy; a reset discards everything queued.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PW'(n_out);
            tail  <= tail + PW'(n_in);
            count <= count + CW'(n_in) - CW'(n_out);
        end
    end

    // Sequencer with registered RAM write ports and init_done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
`ifdef RAM_WR_QUEUE_INIT_EN
            state     <= ST_INIT;
            init_done <= 1'b0;
            init_idx  <= '0;
`else
            state     <= ST_RUN;
            init_done <= 1'b1;
`endif
            we1    <= 1'b0;
            we2    <= 1'b0;
            waddr1 <= '0;
            waddr2 <= '0;
            wdata1 <= '0;
            wdata2 <= '0;
        end else if (state == ST_RUN) begin
            we1 <= (n_out != 2'd0);
            we2 <= (n_out == 2'd2);
            if (n_out != 2'd0) begin
                waddr1 <= q_addr[head];
                wdata1 <= q_data[head];
            end
            if (n_out == 2'd2) begin
                waddr2 <= q_addr[head_p1];
                wdata2 <= q_data[head_p1];
            end
        end else begin
`ifdef RAM_WR_QUEUE_INIT_EN
            we1      <= 1'b1;
            waddr1   <= init_idx[ADDR_WIDTH-1:0];
            wdata1   <= '0;
            we2      <= (init_idx_p1 < DD);
            waddr2   <= init_idx_p1[ADDR_WIDTH-1:0];
            wdata2   <= '0;
            init_idx <= init_idx_p2;
            if (init_idx_p2 >= DD) begin
                state     <= ST_RUN;
                init_done <= 1'b1;
            end
`else
            state     <= ST_RUN;
            init_done <= 1'b1;
`endif
        end
    end
endmodule

// File: tb/tb_ram_wr_queue.sv
// tb_ram_wr_queue: queue-based reference model plus directed literal checks
// and a randomized traffic phase for ram_wr_queue.
module tb_ram_wr_queue;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int DD = 32;
    localparam int QD = 8;
`ifdef RAM_WR_QUEUE_INIT_EN
    localparam bit INIT_EN = 1'b1;
`else
    localparam bit INIT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid1 = 1'b0, in_valid2 = 1'b0, drain_en = 1'b0;
    logic [AW-1:0] in_addr1 = '0, in_addr2 = '0;
    logic [DW-1:0] in_data1 = '0, in_data2 = '0;
    logic          in_ready, we1, we2, init_done;
    logic [AW-1:0] waddr1, waddr2;
    logic [DW-1:0] wdata1, wdata2;
    logic [3:0]    count;

    ram_wr_queue #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DATA_DEPTH(DD), .QUEUE_DEPTH(QD)) dut (
        .clk(clk), .reset(reset),
        .in_valid1(in_valid1), .in_addr1(in_addr1), .in_data1(in_data1),
        .in_valid2(in_valid2), .in_addr2(in_addr2), .in_data2(in_data2),
        .in_ready(in_ready), .drain_en(drain_en),
        .we1(we1), .we2(we2), .waddr1(waddr1), .waddr2(waddr2),
        .wdata1(wdata1), .wdata2(wdata2), .count(count), .init_done(init_done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a queue of pending writes and the expected RAM port values.
    typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; } ent_t;
    ent_t          mq[$];
    ent_t          e;
    bit            m_run = 1'b0, m_done = 1'b0;
    int            m_idx = 0;
    int            sz;
    bit            rdy;
    bit            m_we1 = 1'b0, m_we2 = 1'b0;
    logic [AW-1:0] m_a1 = '0, m_a2 = '0;
    logic [DW-1:0] m_d1 = '0, m_d2 = '0;
    bit            chk_on = 1'b0;

    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
            mq.delete();
            m_we1 = 0; m_we2 = 0; m_a1 = '0; m_a2 = '0; m_d1 = '0; m_d2 = '0;
            m_idx = 0; m_run = !INIT_EN; m_done = !INIT_EN;
        end else if (!m_run) begin
            m_we1 = 1; m_a1 = AW'(m_idx); m_d1 = '0;
            m_we2 = (m_idx + 1 < DD); m_a2 = AW'(m_idx + 1); m_d2 = '0;
            m_idx += 2;
            if (m_idx >= DD) begin m_run = 1; m_done = 1; end
        end else begin
            sz = mq.size();
            rdy = (QD - sz >= 2);
            m_we1 = 0; m_we2 = 0;
            if (drain_en && sz >= 1) begin e = mq.pop_front(); m_we1 = 1; m_a1 = e.a; m_d1 = e.d; end
            if (drain_en && sz >= 2) begin e = mq.pop_front(); m_we2 = 1; m_a2 = e.a; m_d2 = e.d; end
            if (rdy && in_valid1) mq.push_back({in_addr1, in_data1});
            if (rdy && in_valid2) mq.push_back({in_addr2, in_data2});
        end
    end

    // Per-cycle comparison against the model, sampled mid-cycle.
    initial forever begin
        @(negedge clk);
        if (chk_on && !reset) begin
            chk("m_in_ready", in_ready, m_run && (QD - mq.size() >= 2));
            chk("m_count", count, mq.size());
            chk("m_init_done", init_done, m_done);
            chk("m_we1", we1, m_we1);
            chk("m_we2", we2, m_we2);
            if (m_we1) begin chk("m_waddr1", waddr1, m_a1); chk("m_wdata1", wdata1, m_d1); end
            if (m_we2) begin chk("m_waddr2", waddr2, m_a2); chk("m_wdata2", wdata2, m_d2); end
        end
    end

    // Apply inputs for one posedge; call at a negedge, returns at the next negedge.
    task automatic drive(input bit v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                         input bit v2, input logic [AW-1:0] a2, input logic [DW-1:0] d2,
                         input bit de);
        in_valid1 = v1; in_addr1 = a1; in_data1 = d1;
        in_valid2 = v2; in_addr2 = a2; in_data2 = d2;
        drain_en = de;
        @(negedge clk);
    endtask

    task automatic idle(input bit de);
        drive(0, '0, '0, 0, '0, '0, de);
    endtask

    task automatic after_reset();
        chk("rst_count", count, 0);
        chk("rst_we1", we1, 0);
        chk("rst_we2", we2, 0);
`ifdef RAM_WR_QUEUE_INIT_EN
        chk("init_done_low", init_done, 0);
        chk("init_ready_low", in_ready, 0);
        for (int i = 0; i < (DD + 1) / 2; i++) begin
            drive(1, 5'd9, 32'h1234, 1, 5'd10, 32'h5678, 1);
            chk("clr_we1", we1, 1);
            chk("clr_waddr1", waddr1, 2 * i);
            chk("clr_wdata1", wdata1, 0);
            chk("clr_we2", we2, (2 * i + 1 < DD));
            if (2 * i + 1 < DD) chk("clr_waddr2", waddr2, 2 * i + 1);
            chk("clr_init_done", init_done, (i == (DD + 1) / 2 - 1));
        end
        idle(0);
        chk("post_clr_count", count, 0);
`endif
        chk("run_init_done", init_done, 1);
        chk("run_ready", in_ready, 1);
    endtask

    initial begin
        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk_on = 1'b1;
        after_reset();

        // single write reaches port 1 one edge after acceptance
        drive(1, 5'd5, 32'hDEADBEEF, 0, '0, '0, 1);
        chk("t2_count_after_accept", count, 1);
        chk("t2_we1_not_bypassed", we1, 0);
        idle(1);
        chk("t2_we1", we1, 1);
        chk("t2_waddr1", waddr1, 5);
        chk("t2_wdata1", wdata1, 32'hDEADBEEF);
        chk("t2_we2", we2, 0);
        chk("t2_count", count, 0);

        // same-address pair keeps program order across ports
        drive(1, 5'd3, 32'hA, 1, 5'd3, 32'hB, 1);
        idle(1);
        chk("t3_we1", we1, 1);
        chk("t3_we2", we2, 1);
        chk("t3_waddr1", waddr1, 3);
        chk("t3_waddr2", waddr2, 3);
        chk("t3_wdata1", wdata1, 32'hA);
        chk("t3_wdata2", wdata2, 32'hB);
        idle(1);

        // fill to full with drain held off, then drain four ordered pairs
        for (int k = 0; k < 3; k++)
            drive(1, AW'(10 + 2 * k), DW'(100 + 2 * k), 1, AW'(11 + 2 * k), DW'(101 + 2 * k), 0);
        chk("t4_count6", count, 6);
        chk("t4_ready6", in_ready, 1);
        drive(1, 5'd16, 32'd106, 1, 5'd17, 32'd107, 0);
        chk("t4_count8", count, 8);
        chk("t4_ready8", in_ready, 0);
        drive(1, 5'd20, 32'd1, 1, 5'd21, 32'd2, 0);
        chk("t4_full_ignored", count, 8);
        for (int k = 0; k < 4; k++) begin
            idle(1);
            chk("t4_pair_waddr1", waddr1, 10 + 2 * k);
            chk("t4_pair_waddr2", waddr2, 11 + 2 * k);
            chk("t4_pair_wdata2", wdata2, 101 + 2 * k);
        end
        chk("t4_empty", count, 0);

        // odd occupancy drains as a pair then a single
        drive(1, 5'd7, 32'd70, 1, 5'd8, 32'd80, 0);
        drive(0, '0, '0, 1, 5'd9, 32'd90, 0);
        chk("t5_count3", count, 3);
        idle(1);
        chk("t5_c1_we1", we1, 1);
        chk("t5_c1_we2", we2, 1);
        chk("t5_c1_waddr2", waddr2, 8);
        chk("t5_c1_count", count, 1);
        idle(1);
        chk("t5_c2_we1", we1, 1);
        chk("t5_c2_waddr1", waddr1, 9);
        chk("t5_c2_we2", we2, 0);
        idle(1);
        chk("t5_c3_we1", we1, 0);
        chk("t5_c3_we2", we2, 0);

        // asynchronous reset in the middle of a drain
        drive(1, 5'd1, 32'd11, 1, 5'd2, 32'd22, 0);
        drive(1, 5'd3, 32'd33, 1, 5'd4, 32'd44, 0);
        drive(1, 5'd5, 32'd55, 0, '0, '0, 0);
        chk("t6_count5", count, 5);
        idle(1);
        chk("t6_draining", we1 & we2, 1);
        #2 reset = 1'b1;
        #1;
        chk("t6_rst_we1", we1, 0);
        chk("t6_rst_we2", we2, 0);
        chk("t6_rst_count", count, 0);
        chk("t6_rst_ready", in_ready, !INIT_EN);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        after_reset();

        // randomized traffic with alternating drain pressure
        for (int i = 0; i < 2000; i++) begin
            drive($urandom_range(0, 1), AW'($urandom), $urandom,
                  $urandom_range(0, 1), AW'($urandom), $urandom,
                  ((i / 200) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0));
        end
        for (int i = 0; i < 8; i++) idle(1);
        chk("final_empty", count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
